// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith ALU plus an iterative shift-add
// multiplier that stalls the upstream pipeline while it runs.
module ex_stage #(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned MUL_ITER = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [2:0]        ex_alusel,
  input  logic [4:0]        ex_aluop,
  input  logic [WORD_W-1:0] ex_srcl,
  input  logic [WORD_W-1:0] ex_srcr,
  input  logic [WORD_W-1:0] ex_offset,
  input  logic [3:0]        ex_memop,
  input  logic [4:0]        ex_dest,
  input  logic              ex_writeEnable,
  output logic              stall_req,
  output logic [WORD_W-1:0] mem_result,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_storeData,
  output logic [3:0]        mem_memop,
  output logic [4:0]        mem_dest,
  output logic              mem_writeEnable
);

  localparam int unsigned SH_W  = $clog2(WORD_W);
  localparam int unsigned CNT_W = $clog2(MUL_ITER);

  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_ARITH = 3'd3;
  localparam logic [2:0] SEL_MUL   = 3'd4;
  localparam logic [3:0] MEMOP_NOP = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [WORD_W-1:0]   mcand;
  logic [WORD_W-1:0]   mplier;
  logic [WORD_W-1:0]   acc;

  logic [WORD_W-1:0]   alu_res;
  logic                alu_valid;
  logic [SH_W-1:0]     sh_amt;

  assign sh_amt = ex_srcl[SH_W-1:0];

  // Single-cycle ALU; alu_valid marks a defined unit/op pair
  always_comb begin
    alu_res   = '0;
    alu_valid = 1'b0;
    case (ex_alusel)
      SEL_LOGIC: begin
        alu_valid = 1'b1;
        case (ex_aluop)
          5'd0:    alu_res = ex_srcl & ex_srcr;
          5'd1:    alu_res = ex_srcl | ex_srcr;
          5'd2:    alu_res = ex_srcl ^ ex_srcr;
          5'd3:    alu_res = ~(ex_srcl | ex_srcr);
          5'd4:    alu_res = {ex_srcr[15:0], 16'h0000};
          default: alu_valid = 1'b0;
        endcase
      end
      SEL_SHIFT: begin
        alu_valid = 1'b1;
        case (ex_aluop)
          5'd0:    alu_res = ex_srcr << sh_amt;
          5'd1:    alu_res = ex_srcr >> sh_amt;
          5'd2:    alu_res = WORD_W'($signed(ex_srcr) >>> sh_amt);
          default: alu_valid = 1'b0;
        endcase
      end
      SEL_ARITH: begin
        alu_valid = 1'b1;
        case (ex_aluop)
          5'd0:    alu_res = ex_srcl + ex_srcr;
          5'd1:    alu_res = ex_srcl - ex_srcr;
          5'd2:    alu_res = WORD_W'($signed(ex_srcl) < $signed(ex_srcr));
          5'd3:    alu_res = WORD_W'(ex_srcl < ex_srcr);
          default: alu_valid = 1'b0;
        endcase
      end
      default: begin
        alu_res   = '0;
        alu_valid = 1'b0;
      end
    endcase
  end

  // Stall covers the MUL entry cycle plus every BUSY cycle; a flush cancels entry
  assign stall_req = !rst &&
                     ((state == ST_BUSY) ||
                      (state == ST_IDLE && ex_alusel == SEL_MUL && !flush));

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      mcand           <= '0;
      mplier          <= '0;
      acc             <= '0;
      mem_result      <= '0;
      mem_addr        <= '0;
      mem_storeData   <= '0;
      mem_memop       <= MEMOP_NOP;
      mem_dest        <= '0;
      mem_writeEnable <= 1'b0;
    end else begin
      mem_addr      <= ex_srcl + ex_offset;
      mem_storeData <= ex_srcr;
      if (flush) begin
        state           <= ST_IDLE;
        cnt             <= '0;
        mem_result      <= '0;
        mem_memop       <= MEMOP_NOP;
        mem_dest        <= '0;
        mem_writeEnable <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ex_alusel == SEL_MUL) begin
              mcand           <= ex_srcl;
              mplier          <= ex_srcr;
              acc             <= '0;
              cnt             <= '0;
              state           <= ST_BUSY;
              mem_result      <= '0;
              mem_memop       <= MEMOP_NOP;
              mem_dest        <= '0;
              mem_writeEnable <= 1'b0;
            end else begin
              mem_result      <= alu_res;
              mem_memop       <= ex_memop;
              mem_dest        <= ex_dest;
              mem_writeEnable <= ex_writeEnable & alu_valid;
            end
          end
          ST_BUSY: begin
            // One shift-add step per cycle; low word of the product only
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(MUL_ITER - 1)) state <= ST_DONE;
            mem_result      <= '0;
            mem_memop       <= MEMOP_NOP;
            mem_dest        <= '0;
            mem_writeEnable <= 1'b0;
          end
          ST_DONE: begin
            // ID/EX still holds the MUL here; it advances on this same edge
            mem_result      <= acc;
            mem_memop       <= ex_memop;
            mem_dest        <= ex_dest;
            mem_writeEnable <= ex_writeEnable;
            state           <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU sweep, multiplier timing, flush and reset.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  ex_alusel;
  logic [4:0]  ex_aluop;
  logic [31:0] ex_srcl;
  logic [31:0] ex_srcr;
  logic [31:0] ex_offset;
  logic [3:0]  ex_memop;
  logic [4:0]  ex_dest;
  logic        ex_writeEnable;
  logic        stall_req;
  logic [31:0] mem_result;
  logic [31:0] mem_addr;
  logic [31:0] mem_storeData;
  logic [3:0]  mem_memop;
  logic [4:0]  mem_dest;
  logic        mem_writeEnable;

  int checks = 0;
  int errors = 0;
  int unsigned stall_cnt;

  ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_alusel(ex_alusel), .ex_aluop(ex_aluop),
    .ex_srcl(ex_srcl), .ex_srcr(ex_srcr), .ex_offset(ex_offset),
    .ex_memop(ex_memop), .ex_dest(ex_dest), .ex_writeEnable(ex_writeEnable),
    .stall_req(stall_req),
    .mem_result(mem_result), .mem_addr(mem_addr), .mem_storeData(mem_storeData),
    .mem_memop(mem_memop), .mem_dest(mem_dest), .mem_writeEnable(mem_writeEnable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] sel, input logic [4:0] op,
                        input logic [31:0] l, input logic [31:0] r,
                        input logic [31:0] off, input logic [3:0] mop,
                        input logic [4:0] dst, input logic we);
    ex_alusel = sel; ex_aluop = op; ex_srcl = l; ex_srcr = r;
    ex_offset = off; ex_memop = mop; ex_dest = dst; ex_writeEnable = we;
  endtask

  // Drive a MUL and follow it through the stall window to the result edge
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dst, input logic [31:0] exp);
    set_op(3'd4, 5'd0, a, b, 32'h0, 4'd1, dst, 1'b1);
    #1;
    stall_cnt = 0;
    while (stall_req === 1'b1 && stall_cnt < 100) begin
      stall_cnt++;
      tick();
      check({tag, "_bubble_we"}, 32'(mem_writeEnable), 32'd0);
    end
    check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'd33);
    check({tag, "_done_stall_low"}, 32'(stall_req), 32'd0);
    tick();
    check({tag, "_result"}, mem_result, exp);
    check({tag, "_we"}, 32'(mem_writeEnable), 32'd1);
    check({tag, "_dest"}, 32'(mem_dest), 32'(dst));
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    set_op(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0);
    tick();
    tick();
    check("rst_result", mem_result, 32'h0);
    check("rst_we", 32'(mem_writeEnable), 32'd0);
    check("rst_memop", 32'(mem_memop), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    rst = 1'b0;

    // Single-cycle sweep
    set_op(3'd1, 5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 4'd1, 5'd5, 1'b1);
    #1;
    check("and_stall", 32'(stall_req), 32'd0);
    tick();
    check("and_result", mem_result, 32'hF000F000);
    check("and_we", 32'(mem_writeEnable), 32'd1);
    check("and_dest", 32'(mem_dest), 32'd5);
    check("and_memop", 32'(mem_memop), 32'd1);

    set_op(3'd1, 5'd3, 32'h0, 32'h0, 32'h0, 4'd1, 5'd6, 1'b1);
    tick();
    check("nor_result", mem_result, 32'hFFFFFFFF);

    set_op(3'd1, 5'd4, 32'h0, 32'h00001234, 32'h0, 4'd1, 5'd6, 1'b1);
    tick();
    check("lui_result", mem_result, 32'h12340000);

    set_op(3'd2, 5'd2, 32'h4, 32'h80000000, 32'h0, 4'd1, 5'd7, 1'b1);
    #1;
    check("sra_stall", 32'(stall_req), 32'd0);
    tick();
    check("sra_result", mem_result, 32'hF8000000);

    set_op(3'd2, 5'd1, 32'h4, 32'h80000000, 32'h0, 4'd1, 5'd7, 1'b1);
    tick();
    check("srl_result", mem_result, 32'h08000000);

    set_op(3'd2, 5'd0, 32'h24, 32'h00000003, 32'h0, 4'd1, 5'd7, 1'b1);
    tick();
    check("sll_amt_low5", mem_result, 32'h00000030);

    set_op(3'd3, 5'd2, 32'hFFFFFFFF, 32'h1, 32'h0, 4'd1, 5'd8, 1'b1);
    tick();
    check("slt_result", mem_result, 32'h1);

    set_op(3'd3, 5'd3, 32'hFFFFFFFF, 32'h1, 32'h0, 4'd1, 5'd8, 1'b1);
    tick();
    check("sltu_result", mem_result, 32'h0);

    set_op(3'd3, 5'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 4'd1, 5'd8, 1'b1);
    tick();
    check("add_wrap", mem_result, 32'h0);
    check("add_we", 32'(mem_writeEnable), 32'd1);

    set_op(3'd3, 5'd1, 32'h5, 32'h7, 32'h0, 4'd1, 5'd8, 1'b1);
    tick();
    check("sub_wrap", mem_result, 32'hFFFFFFFE);

    // Undefined op: result 0, write suppressed, memop passed through
    set_op(3'd1, 5'd7, 32'hFFFF, 32'hFFFF, 32'h0, 4'd1, 5'd9, 1'b1);
    tick();
    check("undef_result", mem_result, 32'h0);
    check("undef_we", 32'(mem_writeEnable), 32'd0);
    check("undef_memop", 32'(mem_memop), 32'd1);

    // Load address generation
    set_op(3'd3, 5'd0, 32'h00001000, 32'h00000055, 32'hFFFFFFFC, 4'd2, 5'd7, 1'b1);
    tick();
    check("load_addr", mem_addr, 32'h00000FFC);
    check("load_memop", 32'(mem_memop), 32'd2);
    check("load_dest", 32'(mem_dest), 32'd7);
    check("load_store_data", mem_storeData, 32'h00000055);

    // Multiplier, then back-to-back pair
    run_mul("mul1", 32'h00012345, 32'h00000010, 5'd10, 32'h00123450);
    run_mul("mul2", 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'h00000001);
    run_mul("mul3", 32'h7, 32'h6, 5'd12, 32'd42);

    // Flush during BUSY at cnt=5
    set_op(3'd4, 5'd0, 32'h3, 32'h5, 32'h0, 4'd1, 5'd13, 1'b1);
    repeat (6) tick();
    flush = 1'b1;
    #1;
    check("flush_busy_stall", 32'(stall_req), 32'd1);
    tick();
    flush = 1'b0;
    set_op(3'd1, 5'd1, 32'h1, 32'h2, 32'h0, 4'd1, 5'd14, 1'b1);
    #1;
    check("flush_stall_drop", 32'(stall_req), 32'd0);
    check("flush_bubble_we", 32'(mem_writeEnable), 32'd0);
    tick();
    check("flush_or_result", mem_result, 32'h3);
    check("flush_or_dest", 32'(mem_dest), 32'd14);
    tick();
    check("flush_no_mul_we", 32'(mem_dest), 32'd14);

    // Flush coinciding with MUL entry
    set_op(3'd4, 5'd0, 32'h3, 32'h5, 32'h0, 4'd1, 5'd15, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_entry_stall", 32'(stall_req), 32'd0);
    tick();
    check("flush_entry_we", 32'(mem_writeEnable), 32'd0);
    flush = 1'b0;
    set_op(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0);
    #1;
    check("flush_entry_idle", 32'(stall_req), 32'd0);

    // Reset mid-MUL at BUSY cnt=10
    set_op(3'd4, 5'd0, 32'h9, 32'h9, 32'h0, 4'd1, 5'd16, 1'b1);
    repeat (11) tick();
    check("rstmid_stall_before", 32'(stall_req), 32'd1);
    rst = 1'b1;
    set_op(3'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("rstmid_stall", 32'(stall_req), 32'd0);
    check("rstmid_we", 32'(mem_writeEnable), 32'd0);
    set_op(3'd3, 5'd0, 32'h3, 32'h4, 32'h0, 4'd1, 5'd17, 1'b1);
    #1;
    check("rstmid_idle", 32'(stall_req), 32'd0);
    tick();
    check("rstmid_add", mem_result, 32'd7);
    check("rstmid_add_we", 32'(mem_writeEnable), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
